// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage (master) and dmem_responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder with range check; define DMEM_ALIGN_CHECK_EN
// to also reject byte enables that do not match the address alignment.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        access;
  logic        in_range;
  logic        be_ok;
  logic        acc_err;
  logic [29:0] idx;

  assign idx      = cap_addr[31:2];
  assign in_range = ({2'b00, idx} < DEPTH_WORDS);
  assign accept   = bus.req_valid && bus.req_ready;
  assign access   = (state == BUSY) && (cnt == 4'd0);
  assign acc_err  = !in_range || !be_ok;

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    be_ok = 1'b0;
    case (cap_addr[1:0])
      2'd0:    be_ok = (cap_be == 4'b0001) || (cap_be == 4'b0011) || (cap_be == 4'b1111);
      2'd1:    be_ok = (cap_be == 4'b0010);
      2'd2:    be_ok = (cap_be == 4'b0100) || (cap_be == 4'b1100);
      default: be_ok = (cap_be == 4'b1000);
    endcase
  end
`else
  assign be_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready must drop the instant rst rises, so it is gated by rst directly.
  always_comb begin
    bus.req_ready  = (state == IDLE) && !rst;
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cap_write <= bus.req_write;
          cap_addr  <= bus.req_addr;
          cap_wdata <= bus.req_wdata;
          cap_be    <= bus.req_be;
          cnt       <= 4'(LATENCY - 1);
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata_q <= (acc_err || cap_write) ? '0 : mem[idx[AW-1:0]];
            err_q   <= acc_err;
          end
        end
        RESP: if (bus.resp_ready) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; contents survive rst.
  always_ff @(posedge clk) begin
    if (access && cap_write && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cap_be[i]) mem[idx[AW-1:0]][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default DEPTH_WORDS=1024, LATENCY=2).
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total  = 0;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err,
                         output int lat);
    int guard;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0; bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_err !== 1'b0)
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, want 0/0/0/0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
    total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0)
      $display("FAIL store_resp: got lat=%0d err=%b rdata=%h, want 2/0/00000000", lat, er, rd);
    else passed++;
    run_txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF)
      $display("FAIL load_resp: got lat=%0d err=%b rdata=%h, want 2/0/deadbeef", lat, er, rd);
    else passed++;
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b1, 32'h20, 32'h11223344, 4'b1111, rd, er, lat);
    run_txn(1'b1, 32'h20, 32'h0000AA00, 4'b0010, rd, er, lat);
    run_txn(1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
    total++;
    if (rd !== 32'h1122AA44 || er !== 1'b0)
      $display("FAIL partial_store: got rdata=%h err=%b, want 1122aa44/0", rd, er);
    else passed++;
    run_txn(1'b1, 32'h24, 32'hA1B2C3D4, 4'b1111, rd, er, lat);
    run_txn(1'b1, 32'h24, 32'h55000066, 4'b1001, rd, er, lat);
    run_txn(1'b0, 32'h24, 32'h0, 4'b0001, rd, er, lat);
    total++;
    if (rd !== 32'h55B2C366)
      $display("FAIL partial_store_outer: got rdata=%h, want 55b2c366", rd);
    else passed++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, rd, er, lat);
    run_txn(1'b1, 32'h0FFC, 32'h0BADF00D, 4'b1111, rd, er, lat);
    run_txn(1'b0, 32'h0FFC, 32'h0, 4'b1111, rd, er, lat);
    total++;
    if (rd !== 32'h0BADF00D || er !== 1'b0)
      $display("FAIL last_word: got rdata=%h err=%b, want 0badf00d/0", rd, er);
    else passed++;
    run_txn(1'b1, 32'h1000, 32'h12345678, 4'b1111, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0)
      $display("FAIL oor_store: got err=%b rdata=%h, want 1/00000000", er, rd);
    else passed++;
    run_txn(1'b0, 32'h1000, 32'h0, 4'b1111, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2)
      $display("FAIL oor_load: got err=%b rdata=%h lat=%0d, want 1/00000000/2", er, rd, lat);
    else passed++;
    run_txn(1'b0, 32'h0, 32'h0, 4'b1111, rd, er, lat);
    total++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0)
      $display("FAIL oor_no_alias: got rdata=%h err=%b, want cafef00d/0", rd, er);
    else passed++;
  endtask

  task automatic test_backpressure();
    int lat; int bad;
    bus.req_write = 1'b0; bus.req_addr = 32'h10; bus.req_be = 4'b1111; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF ||
          bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    total++;
    if (bad != 0 || lat !== 2)
      $display("FAIL backpressure_hold: got %0d unstable cycles lat=%0d, want 0/2", bad, lat);
    else passed++;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'h0 ||
        bus.resp_err !== 1'b0)
      $display("FAIL backpressure_release: got valid=%b ready=%b rdata=%h err=%b, want 0/1/0/0",
               bus.resp_valid, bus.req_ready, bus.resp_rdata, bus.resp_err);
    else passed++;
  endtask

  task automatic test_input_hold();
    logic [31:0] rd; logic er; int lat;
    bus.req_write = 1'b0; bus.req_addr = 32'h10; bus.req_be = 4'b1111; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'hFFFFFFFF;
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    bus.req_valid = 1'b0;
    total++;
    if (bus.resp_rdata !== 32'hDEADBEEF || lat !== 2)
      $display("FAIL input_hold_data: got rdata=%h lat=%0d, want deadbeef/2", bus.resp_rdata, lat);
    else passed++;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    run_txn(1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
    total++;
    if (rd !== 32'h1122AA44)
      $display("FAIL input_hold_mem: got rdata=%h, want 1122aa44", rd);
    else passed++;
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b1, 32'h40, 32'h000000AA, 4'b1111, rd, er, lat);
    bus.req_write = 1'b1; bus.req_addr = 32'h40; bus.req_wdata = 32'h55;
    bus.req_be = 4'b1111; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_err !== 1'b0)
      $display("FAIL reset_mid_busy: got ready=%b valid=%b rdata=%h err=%b, want 0/0/0/0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b0, 32'h40, 32'h0, 4'b1111, rd, er, lat);
    total++;
    if (rd !== 32'h000000AA || er !== 1'b0)
      $display("FAIL reset_abort_store: got rdata=%h err=%b, want 000000aa/0", rd, er);
    else passed++;
  endtask

  task automatic test_align();
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b0, 32'h2, 32'h0, 4'b1111, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    total++;
    if (er !== 1'b1 || rd !== 32'h0)
      $display("FAIL align_word_misaligned: got err=%b rdata=%h, want 1/00000000", er, rd);
    else passed++;
`else
    total++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D)
      $display("FAIL align_ignored: got err=%b rdata=%h, want 0/cafef00d", er, rd);
    else passed++;
`endif
    run_txn(1'b0, 32'h2, 32'h0, 4'b1100, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D)
      $display("FAIL align_halfword_legal: got err=%b rdata=%h, want 0/cafef00d", er, rd);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_store();
    test_out_of_range();
    test_backpressure();
    test_input_hold();
    test_reset_mid_busy();
    test_align();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
